// File: rtl/arbitro_memoria_datos.sv
// Two-port round-robin arbiter/sequencer in front of the single data memory (memoria_datos).
// Optional macro PRIORIDAD_FIJA_EN: port 0 always wins simultaneous requests.
module arbitro_memoria_datos #(
  parameter int unsigned ANCHO_DIR  = 8,
  parameter int unsigned ANCHO_DATO = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  esc0,
  input  logic [ANCHO_DIR-1:0]  direc0,
  input  logic [ANCHO_DATO-1:0] dato0,
  output logic                  ack0,
  output logic [ANCHO_DATO-1:0] leido0,
  input  logic                  req1,
  input  logic                  esc1,
  input  logic [ANCHO_DIR-1:0]  direc1,
  input  logic [ANCHO_DATO-1:0] dato1,
  output logic                  ack1,
  output logic [ANCHO_DATO-1:0] leido1,
  output logic                  EscrMem,
  output logic                  LeerMem,
  output logic [ANCHO_DIR-1:0]  Direc,
  output logic [ANCHO_DATO-1:0] Datain,
  input  logic [ANCHO_DATO-1:0] Dataout
);

  localparam logic [1:0] OCIOSO    = 2'd0;
  localparam logic [1:0] ACCESO    = 2'd1;
  localparam logic [1:0] RESPUESTA = 2'd2;

  logic [1:0]            state_q, state_d;
  logic                  ganador_q, ganador_d;
  logic                  esc_q, esc_d;
  logic [ANCHO_DIR-1:0]  direc_q, direc_d;
  logic [ANCHO_DATO-1:0] dato_q, dato_d;
  logic [ANCHO_DATO-1:0] leido0_q, leido0_d;
  logic [ANCHO_DATO-1:0] leido1_q, leido1_d;
  logic                  gana;

`ifdef PRIORIDAD_FIJA_EN
  assign gana = ~req0;
`else
  logic ultimo_q, ultimo_d;

  // On a conflict the port that was not served last wins.
  always_comb begin
    gana = ~req0;
    if (req0 && req1) begin
      gana = ~ultimo_q;
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    ganador_d = ganador_q;
    esc_d     = esc_q;
    direc_d   = direc_q;
    dato_d    = dato_q;
    leido0_d  = leido0_q;
    leido1_d  = leido1_q;
`ifndef PRIORIDAD_FIJA_EN
    ultimo_d  = ultimo_q;
`endif
    case (state_q)
      OCIOSO: begin
        if (req0 || req1) begin
          ganador_d = gana;
          esc_d     = gana ? esc1   : esc0;
          direc_d   = gana ? direc1 : direc0;
          dato_d    = gana ? dato1  : dato0;
          state_d   = ACCESO;
        end
      end
      ACCESO: begin
        if (!esc_q) begin
          if (ganador_q) begin
            leido1_d = Dataout;
          end else begin
            leido0_d = Dataout;
          end
        end
`ifndef PRIORIDAD_FIJA_EN
        ultimo_d = ganador_q;
`endif
        state_d = RESPUESTA;
      end
      RESPUESTA: state_d = OCIOSO;
      default:   state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= OCIOSO;
      ganador_q <= 1'b0;
      esc_q     <= 1'b0;
      direc_q   <= '0;
      dato_q    <= '0;
      leido0_q  <= '0;
      leido1_q  <= '0;
`ifndef PRIORIDAD_FIJA_EN
      ultimo_q  <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      ganador_q <= ganador_d;
      esc_q     <= esc_d;
      direc_q   <= direc_d;
      dato_q    <= dato_d;
      leido0_q  <= leido0_d;
      leido1_q  <= leido1_d;
`ifndef PRIORIDAD_FIJA_EN
      ultimo_q  <= ultimo_d;
`endif
    end
  end

  // Memory strobes only during the single access cycle; address/data hold the last latch.
  assign EscrMem = (state_q == ACCESO) &  esc_q;
  assign LeerMem = (state_q == ACCESO) & ~esc_q;
  assign Direc   = direc_q;
  assign Datain  = dato_q;

  assign ack0   = (state_q == RESPUESTA) & ~ganador_q;
  assign ack1   = (state_q == RESPUESTA) &  ganador_q;
  assign leido0 = leido0_q;
  assign leido1 = leido1_q;

endmodule

// File: tb/tb_arbitro_memoria_datos.sv
// Self-checking bench for arbitro_memoria_datos: vector table, scoreboard on acks,
// plus hand sequences for round-robin, mid-access reset and late input changes.
module tb_arbitro_memoria_datos;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, esc0, req1, esc1;
  logic [7:0]  direc0, direc1;
  logic [31:0] dato0, dato1;
  logic        ack0, ack1;
  logic [31:0] leido0, leido1;
  logic        EscrMem, LeerMem;
  logic [7:0]  Direc;
  logic [31:0] Datain;
  logic [31:0] Dataout;

  always #5 clk = ~clk;

  arbitro_memoria_datos #(
    .ANCHO_DIR  (8),
    .ANCHO_DATO (32)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .esc0    (esc0),
    .direc0  (direc0),
    .dato0   (dato0),
    .ack0    (ack0),
    .leido0  (leido0),
    .req1    (req1),
    .esc1    (esc1),
    .direc1  (direc1),
    .dato1   (dato1),
    .ack1    (ack1),
    .leido1  (leido1),
    .EscrMem (EscrMem),
    .LeerMem (LeerMem),
    .Direc   (Direc),
    .Datain  (Datain),
    .Dataout (Dataout)
  );

  // Behavioural memoria_datos: combinational read, write on the rising edge.
  logic [31:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge clk) if (EscrMem) mem[Direc] <= Datain;
  assign Dataout = LeerMem ? mem[Direc] : 32'h0;

  typedef struct {
    bit          port;
    bit          esc;
    logic [7:0]  dir;
    logic [31:0] dato;
    logic [31:0] leido_exp;
    bit          suelta;
  } vec_t;

  typedef struct {
    bit          port;
    logic [31:0] leido;
  } sb_t;

  int          checks = 0;
  int          errors = 0;
  sb_t         sb_q [$];
  logic [31:0] lei0_exp = 32'h0;
  logic [31:0] lei1_exp = 32'h0;
  vec_t        vecs [10];

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_w(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Invariants every cycle, and the ack scoreboard.
  always @(negedge clk) begin
    sb_t e;
    chk_b("mem_excl", EscrMem & LeerMem, 1'b0);
    chk_b("ack_excl", ack0 & ack1, 1'b0);
    if (ack0 | ack1) begin
      if (sb_q.size() == 0) begin
        chk_b("ack_spurious", ack0 | ack1, 1'b0);
      end else begin
        e = sb_q.pop_front();
        chk_b("sb_port", ack1, e.port);
        chk_w("sb_leido", ack1 ? leido1 : leido0, e.leido);
      end
    end
  end

  task automatic drive(input bit p, input logic r, input logic e, input logic [7:0] d,
                       input logic [31:0] w);
    if (p) begin
      req1 = r; esc1 = e; direc1 = d; dato1 = w;
    end else begin
      req0 = r; esc0 = e; direc0 = d; dato0 = w;
    end
  endtask

  task automatic push_exp(input bit p);
    sb_t e;
    e.port  = p;
    e.leido = p ? lei1_exp : lei0_exp;
    sb_q.push_back(e);
  endtask

  // Called #1 after an edge with the DUT idle; returns #1 after the ack edge.
  task automatic run_vec(input vec_t v);
    if (v.port) req0 = 1'b0; else req1 = 1'b0;
    drive(v.port, 1'b1, v.esc, v.dir, v.dato);
    if (!v.esc) begin
      if (v.port) lei1_exp = v.leido_exp; else lei0_exp = v.leido_exp;
    end
    push_exp(v.port);
    @(posedge clk); #1;
    chk_b("acc_escr", EscrMem, v.esc);
    chk_b("acc_leer", LeerMem, !v.esc);
    chk_w("acc_direc", 32'(Direc), 32'(v.dir));
    chk_w("acc_datain", Datain, v.dato);
    chk_b("acc_noack", ack0 | ack1, 1'b0);
    // Inputs after the latch must be ignored.
    drive(v.port, !v.suelta, !v.esc, ~v.dir, ~v.dato);
    @(posedge clk); #1;
    chk_b("rsp_ack0", ack0, !v.port);
    chk_b("rsp_ack1", ack1, v.port);
    chk_b("rsp_strobes", EscrMem | LeerMem, 1'b0);
    chk_w("rsp_leido0", leido0, lei0_exp);
    chk_w("rsp_leido1", leido1, lei1_exp);
    @(posedge clk); #1;
    chk_b("post_noack", ack0 | ack1, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk_b({tag, "_escr"}, EscrMem, 1'b0);
    chk_b({tag, "_leer"}, LeerMem, 1'b0);
    chk_w({tag, "_direc"}, 32'(Direc), 32'h0);
    chk_w({tag, "_datain"}, Datain, 32'h0);
    chk_b({tag, "_ack0"}, ack0, 1'b0);
    chk_b({tag, "_ack1"}, ack1, 1'b0);
    chk_w({tag, "_leido0"}, leido0, 32'h0);
    chk_w({tag, "_leido1"}, leido1, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit   orden [4];
    bit   got;
    vec_t v;

    vecs[0] = '{port:1'b0, esc:1'b1, dir:8'h00, dato:32'h0000_0060, leido_exp:32'h0, suelta:1'b0};
    vecs[1] = '{port:1'b1, esc:1'b0, dir:8'h00, dato:32'h1111_1111, leido_exp:32'h0000_0060,
                suelta:1'b0};
    vecs[2] = '{port:1'b0, esc:1'b1, dir:8'h02, dato:32'h0000_000C, leido_exp:32'h0, suelta:1'b0};
    vecs[3] = '{port:1'b0, esc:1'b0, dir:8'h02, dato:32'h2222_2222, leido_exp:32'h0000_000C,
                suelta:1'b0};
    vecs[4] = '{port:1'b1, esc:1'b1, dir:8'hFF, dato:32'hDEAD_BEEF, leido_exp:32'h0, suelta:1'b0};
    vecs[5] = '{port:1'b0, esc:1'b0, dir:8'hFF, dato:32'h0, leido_exp:32'hDEAD_BEEF, suelta:1'b0};
    vecs[6] = '{port:1'b1, esc:1'b0, dir:8'h02, dato:32'h0, leido_exp:32'h0000_000C, suelta:1'b0};
    vecs[7] = '{port:1'b1, esc:1'b1, dir:8'h80, dato:32'hA5A5_5A5A, leido_exp:32'h0, suelta:1'b1};
    vecs[8] = '{port:1'b1, esc:1'b0, dir:8'h80, dato:32'h0, leido_exp:32'hA5A5_5A5A, suelta:1'b0};
    vecs[9] = '{port:1'b0, esc:1'b0, dir:8'h00, dato:32'h0, leido_exp:32'h0000_0060, suelta:1'b1};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle");

    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;

    // Fresh reset so port 0 wins the first conflict, then both requests held.
    rst_n = 1'b0;
    lei0_exp = 32'h0;
    lei1_exp = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
`ifdef PRIORIDAD_FIJA_EN
    orden[0] = 1'b0; orden[1] = 1'b0; orden[2] = 1'b0; orden[3] = 1'b0;
`else
    orden[0] = 1'b0; orden[1] = 1'b1; orden[2] = 1'b0; orden[3] = 1'b1;
`endif
    for (int k = 0; k < 4; k++) begin
      if (orden[k]) lei1_exp = 32'h0000_000C; else lei0_exp = 32'h0000_0060;
      push_exp(orden[k]);
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 8'h02, 32'h0);
    for (int k = 0; k < 4; k++) begin
      got = 1'b0;
      for (int c = 0; c < 6 && !got; c++) begin
        @(posedge clk); #1;
        if (ack0 | ack1) begin
          got = 1'b1;
          chk_b("rr_order", ack1, orden[k]);
        end
      end
      if (!got) begin
        checks++;
        errors++;
        $display("FAIL rr_timeout: got no ack expected ack for grant %0d", k);
      end
    end
    req0 = 1'b0;
    req1 = 1'b0;
    @(posedge clk); #1;

    // Reset during the access cycle of a port 1 read: no ack may follow.
    drive(1'b1, 1'b1, 1'b0, 8'h02, 32'h0);
    @(posedge clk); #1;
    chk_b("mid_leer", LeerMem, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    lei0_exp = 32'h0;
    lei1_exp = 32'h0;
    req1 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk_b("post_rst_noack", ack0 | ack1, 1'b0);
    end

    v = '{port:1'b0, esc:1'b0, dir:8'h00, dato:32'h0, leido_exp:32'h0000_0060, suelta:1'b1};
    run_vec(v);
    @(posedge clk); #1;

    chk_w("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
